// File: rtl/conv_window_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_ctrl_if
//  Description : Bundle of the window-request, adder-tree enable and result
//                handshake signals between the convolution window controller
//                and its datapath / downstream writer.
//                master : controller side (drives busy/done/win_*/tree/out_*)
//                slave  : environment side (drives start/win_valid/out_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_window_ctrl_if #(
  parameter int RW = 5,
  parameter int CW = 5
);
  logic          start;
  logic          busy;
  logic          done;
  logic          win_req;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_valid;
  logic          tree;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    input  start, win_valid, out_ready,
    output busy, done, win_req, win_row, win_col, tree,
           out_valid, out_row, out_col, out_last
  );

  modport slave (
    output start, win_valid, out_ready,
    input  busy, done, win_req, win_row, win_col, tree,
           out_valid, out_row, out_col, out_last
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_ctrl
//  Description : Sequences one 3x3 valid-convolution pass over an
//                IMG_H x IMG_W map. Issues window coordinates, enables the
//                PIPE_LAT-stage adder tree, tracks in-flight windows with
//                valid tags and hands clamped results downstream in raster
//                order over a valid/ready handshake.
//  Ports       : clk, rst (async, active-high)
//                bus.start/busy/done      - pass control
//                bus.win_req/row/col/valid - window request to datapath
//                bus.tree                  - adder-tree stage enable
//                bus.out_valid/ready/row/col/last - result handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int STRIDE   = 1,
  parameter int PIPE_LAT = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  conv_window_ctrl_if.master bus
);
  localparam int OUT_W = (IMG_W - 3) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - 3) / STRIDE + 1;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  localparam logic [CW-1:0] LAST_WCOL = CW'((OUT_W - 1) * STRIDE);
  localparam logic [RW-1:0] LAST_WROW = RW'((OUT_H - 1) * STRIDE);
  localparam logic [CW-1:0] LAST_OCOL = CW'(OUT_W - 1);
  localparam logic [RW-1:0] LAST_OROW = RW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_STEP  = CW'(STRIDE);
  localparam logic [RW-1:0] ROW_STEP  = RW'(STRIDE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [RW-1:0]       win_row_q, win_row_d;
  logic [CW-1:0]       win_col_q, win_col_d;
  logic [RW-1:0]       out_row_q, out_row_d;
  logic [CW-1:0]       out_col_q, out_col_d;
  logic [PIPE_LAT-1:0] vtag_q, vtag_d;
  logic [PIPE_LAT-1:0] vtag_shift;

  logic busy, win_req, done;
  logic out_valid, tree, accept, out_hs;
  logic last_win, at_last_out;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_row_q <= '0;
      win_col_q <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      vtag_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      vtag_q    <= vtag_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      // A last-result handshake in the same cycle as the last accept skips
      // DRAIN entirely.
      S_RUN:   if (accept && last_win)
                 state_d = (out_hs && at_last_out) ? S_DONE : S_DRAIN;
      S_DRAIN: if (out_hs && at_last_out) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ state outputs
  always_comb begin
    busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    win_req = (state_q == S_RUN);
    done    = (state_q == S_DONE);
  end

  // ------------------------------------------------------- pipeline / counters
  // The tree only advances when its output slot is empty or being drained, so
  // a stalled result stays put without any extra holding register.
  assign out_valid   = vtag_q[PIPE_LAT-1];
  assign tree        = busy & (~out_valid | bus.out_ready);
  assign accept      = win_req & bus.win_valid & tree;
  assign out_hs      = out_valid & bus.out_ready;
  assign last_win    = (win_row_q == LAST_WROW) && (win_col_q == LAST_WCOL);
  assign at_last_out = (out_row_q == LAST_OROW) && (out_col_q == LAST_OCOL);

  if (PIPE_LAT > 1) begin : g_vtag_multi
    assign vtag_shift = {vtag_q[PIPE_LAT-2:0], win_req & bus.win_valid};
  end else begin : g_vtag_single
    assign vtag_shift = win_req & bus.win_valid;
  end

  always_comb begin
    vtag_d    = tree ? vtag_shift : vtag_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;

    // Counters return to zero after the final window / result, so every
    // pass starts from the origin without a separate clear.
    if (accept) begin
      if (win_col_q == LAST_WCOL) begin
        win_col_d = '0;
        win_row_d = last_win ? '0 : win_row_q + ROW_STEP;
      end else begin
        win_col_d = win_col_q + COL_STEP;
      end
    end

    if (out_hs) begin
      if (out_col_q == LAST_OCOL) begin
        out_col_d = '0;
        out_row_d = (out_row_q == LAST_OROW) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.win_req   = win_req;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.tree      = tree;
  assign bus.out_valid = out_valid;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_valid & at_last_out;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_ctrl
//  Description : Self-checking bench. Two controllers run side by side
//                (5x5 stride 1 and 7x7 stride 2, both 3x3 outputs) behind a
//                behavioural 3-stage adder tree with int8 clamping.
//                Expected windows, coordinates and results come from a
//                raster-order reference list built with plain loops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;
  localparam int NI = 2;
  localparam int OW = 3;
  localparam int OH = 3;
  localparam int TOTAL = OW * OH;
  localparam int MAX_CYC = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic win_valid = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  conv_window_ctrl_if #(.RW(3), .CW(3)) if_a ();
  conv_window_ctrl_if #(.RW(3), .CW(3)) if_b ();

  conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .STRIDE(1), .PIPE_LAT(3)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a.master));
  conv_window_ctrl #(.IMG_W(7), .IMG_H(7), .STRIDE(2), .PIPE_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b.master));

  assign if_a.start = start;  assign if_a.win_valid = win_valid;  assign if_a.out_ready = out_ready;
  assign if_b.start = start;  assign if_b.win_valid = win_valid;  assign if_b.out_ready = out_ready;

  logic       busy_o[NI], done_o[NI], wreq_o[NI], tree_o[NI], ov_o[NI], olast_o[NI];
  logic [2:0] wrow_o[NI], wcol_o[NI], orow_o[NI], ocol_o[NI];
  logic signed [7:0] res_o[NI];

  assign busy_o[0] = if_a.busy;      assign busy_o[1] = if_b.busy;
  assign done_o[0] = if_a.done;      assign done_o[1] = if_b.done;
  assign wreq_o[0] = if_a.win_req;   assign wreq_o[1] = if_b.win_req;
  assign tree_o[0] = if_a.tree;      assign tree_o[1] = if_b.tree;
  assign ov_o[0]   = if_a.out_valid; assign ov_o[1]   = if_b.out_valid;
  assign olast_o[0]= if_a.out_last;  assign olast_o[1]= if_b.out_last;
  assign wrow_o[0] = if_a.win_row;   assign wrow_o[1] = if_b.win_row;
  assign wcol_o[0] = if_a.win_col;   assign wcol_o[1] = if_b.win_col;
  assign orow_o[0] = if_a.out_row;   assign orow_o[1] = if_b.out_row;
  assign ocol_o[0] = if_a.out_col;   assign ocol_o[1] = if_b.out_col;

  int pv00 = 3;
  int stride_of[NI] = '{1, 2};

  // Per-window product value; the nine products of a window sum to 9*pval.
  function automatic int pval(input int i, input int r, input int c);
    if (r == 0 && c == 0) return pv00;
    return ((r * 5 + c * 3 + i * 2) % 19) - 9;
  endfunction

  function automatic logic signed [7:0] clamp8(input int v);
    if (v > 127)  return 8'sd127;
    if (v < -128) return -8'sd128;
    return 8'(v);
  endfunction

  // Behavioural adder tree: three enabled stages, garbage when no products.
  for (genvar gi = 0; gi < NI; gi++) begin : g_tree
    int s0, s1, s2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s0 <= 0; s1 <= 0; s2 <= 0;
      end else if (tree_o[gi]) begin
        s0 <= win_valid ? 9 * pval(gi, int'(wrow_o[gi]), int'(wcol_o[gi]))
                        : int'($urandom_range(0, 2000)) - 1000;
        s1 <= s0;
        s2 <= s1;
      end
    end
    assign res_o[gi] = clamp8(s2);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int exp_win[NI][$];
  logic signed [7:0] res_q[NI][$];
  int hs_cnt[NI], acc_cnt[NI], done_cnt[NI], stall_cnt[NI];
  int first_acc_cyc[NI], first_ov_cyc[NI], last_hs_cyc[NI], done_cyc[NI];
  logic signed [7:0] first_res[NI], prev_res[NI];
  logic [2:0] prev_orow[NI], prev_ocol[NI];
  bit prev_stall[NI];

  task automatic chk(input int i, input string tag,
                     input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic begin_pass();
    for (int i = 0; i < NI; i++) begin
      exp_win[i].delete();
      res_q[i].delete();
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          exp_win[i].push_back((r * stride_of[i]) * 16 + c * stride_of[i]);
      hs_cnt[i] = 0; acc_cnt[i] = 0; done_cnt[i] = 0; stall_cnt[i] = 0;
      first_acc_cyc[i] = -1; first_ov_cyc[i] = -1; last_hs_cyc[i] = -1; done_cyc[i] = -1;
      prev_stall[i] = 1'b0;
      first_res[i] = '0;
    end
  endtask

  // Observes the values the coming rising edge will act on.
  task automatic sample_step();
    int e, k;
    logic signed [7:0] er;
    for (int i = 0; i < NI; i++) begin
      if (wreq_o[i] && win_valid && tree_o[i]) begin
        chk(i, "accept_expected", exp_win[i].size() > 0, 1);
        if (exp_win[i].size() > 0) begin
          e = exp_win[i].pop_front();
          chk(i, "win_row", wrow_o[i], e / 16);
          chk(i, "win_col", wcol_o[i], e % 16);
          res_q[i].push_back(clamp8(9 * pval(i, e / 16, e % 16)));
        end
        if (acc_cnt[i] == 0) first_acc_cyc[i] = cyc;
        acc_cnt[i]++;
      end
      if (ov_o[i] === 1'b1 && first_ov_cyc[i] < 0) first_ov_cyc[i] = cyc;
      if (prev_stall[i]) begin
        chk(i, "stall_valid", ov_o[i], 1);
        chk(i, "stall_result", res_o[i], prev_res[i]);
        chk(i, "stall_out_row", orow_o[i], prev_orow[i]);
        chk(i, "stall_out_col", ocol_o[i], prev_ocol[i]);
      end
      prev_stall[i] = 1'b0;
      if (ov_o[i] === 1'b1) begin
        chk(i, "out_last", olast_o[i], hs_cnt[i] == TOTAL - 1);
        if (!out_ready) begin
          chk(i, "stall_tree", tree_o[i], 0);
          prev_stall[i] = 1'b1;
          prev_res[i] = res_o[i];
          prev_orow[i] = orow_o[i];
          prev_ocol[i] = ocol_o[i];
          stall_cnt[i]++;
        end else begin
          k = hs_cnt[i];
          chk(i, "out_row", orow_o[i], k / OW);
          chk(i, "out_col", ocol_o[i], k % OW);
          chk(i, "result_pending", res_q[i].size() > 0, 1);
          if (res_q[i].size() > 0) begin
            er = res_q[i].pop_front();
            chk(i, "result", res_o[i], er);
          end
          if (k == 0) first_res[i] = res_o[i];
          last_hs_cyc[i] = cyc;
          hs_cnt[i]++;
        end
      end else begin
        chk(i, "out_last_idle", olast_o[i], 0);
      end
      if (done_o[i] === 1'b1) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        chk(i, "done_after_all", hs_cnt[i], TOTAL);
      end
    end
  endtask

  task automatic step(input bit wv, input bit rdy, input bit st);
    @(negedge clk);
    start = st; win_valid = wv; out_ready = rdy;
    #1;
    sample_step();
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk(i, {tag, "_busy"}, busy_o[i], 0);
      chk(i, {tag, "_done"}, done_o[i], 0);
      chk(i, {tag, "_win_req"}, wreq_o[i], 0);
      chk(i, {tag, "_win_pos"}, {wrow_o[i], wcol_o[i]}, 0);
      chk(i, {tag, "_tree"}, tree_o[i], 0);
      chk(i, {tag, "_out_valid"}, ov_o[i], 0);
      chk(i, {tag, "_out_pos"}, {orow_o[i], ocol_o[i]}, 0);
      chk(i, {tag, "_out_last"}, olast_o[i], 0);
    end
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random (+ a stray start mid-pass)
  // rmode: 0 always ready, 1 ten-cycle stall, 2 random
  task automatic run_pass(input int vmode, input int rmode, input int pv);
    int n;
    bit wv, rdy, st;
    pv00 = pv;
    begin_pass();
    step(1'b0, 1'b1, 1'b1);
    n = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < MAX_CYC) begin
      wv  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? !(n >= 8 && n < 18)
                                               : ($urandom_range(0, 3) != 0);
      st  = (vmode == 2 && n == 5);
      step(wv, rdy, st);
      if (n == 0)
        for (int i = 0; i < NI; i++) chk(i, "busy_after_start", busy_o[i], 1);
      n++;
    end
    chk(0, "pass_within_budget", n < MAX_CYC, 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NI; i++) begin
      chk(i, "done_pulses", done_cnt[i], 1);
      chk(i, "handshakes", hs_cnt[i], TOTAL);
      chk(i, "accepts", acc_cnt[i], TOTAL);
      chk(i, "windows_left", exp_win[i].size(), 0);
      chk(i, "results_left", res_q[i].size(), 0);
      chk(i, "idle_after_pass", busy_o[i], 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Streaming pass: latency and done timing.
    run_pass(0, 0, 3);
    for (int i = 0; i < NI; i++) begin
      chk(i, "first_result_latency", first_ov_cyc[i] - first_acc_cyc[i], 3);
      chk(i, "done_latency", done_cyc[i] - last_hs_cyc[i], 1);
    end

    // Saturation at both ends of the int8 range.
    run_pass(0, 0, 100);
    for (int i = 0; i < NI; i++) chk(i, "clamp_pos", first_res[i], 127);
    run_pass(0, 0, -100);
    for (int i = 0; i < NI; i++) chk(i, "clamp_neg", first_res[i], -128);

    // Downstream stall.
    run_pass(0, 1, 3);
    for (int i = 0; i < NI; i++) chk(i, "stall_cycles_seen", stall_cnt[i] >= 10, 1);

    // Bubbles from toggling products, then fully random handshakes.
    run_pass(1, 0, 7);
    run_pass(2, 2, -5);

    // Reset in the middle of a pass.
    begin_pass();
    step(1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (3) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NI; i++) chk(i, "no_done_on_abort", done_cnt[i], 0);
    @(negedge clk);
    rst = 1'b0;
    run_pass(0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
